chess_scan_ctrl: RTL and testbench

- Sequencer for the 800x800 chessboard pixel datapath.
- Walks the frame in raster order, one pixel per accepted handshake, and computes each pixel's square colour with counters only (no divide/modulo).
- Streams pixels with coordinates and frame markers to a downstream frame store or display writer.
- Provides start/abort control, a one-cycle done pulse and a latched colour-invert option.

---
 rtl/chess_pkg.sv | 17 +
 rtl/chess_axis_cnt.sv | 81 ++++++++
 rtl/chess_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_chess_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// chess_pkg: shared constants and types for the chessboard scan sequencer.
//   H_PIX_D / V_PIX_D : default frame size in pixels
//   SQ_D              : default square edge in pixels
//   state_e           : sequencer states (IDLE / RUN / FIN), 2-bit encoding
package chess_pkg;

  localparam int H_PIX_D = 800;
  localparam int V_PIX_D = 800;
  localparam int SQ_D    = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/chess_axis_cnt.sv
// chess_axis_cnt: one scan axis (X or Y) of the chessboard sequencer.
// Tracks the position along the axis plus a sub-square counter whose wrap
// toggles the cell parity, so the square colour needs no divide or modulo.
//   CLK, RST : clock, synchronous active-high reset
//   clr      : clear position, sub-square counter and parity
//   step     : advance one position; wraps to 0 after N-1
//   pos      : current position 0..N-1
//   parity   : (pos / SQ) mod 2
//   last     : pos == N-1
module chess_axis_cnt
  import chess_pkg::*;
#(
  parameter int N  = H_PIX_D,
  parameter int SQ = SQ_D,
  parameter int W  = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         step,
  output logic [W-1:0] pos,
  output logic         parity,
  output logic         last
);

  // A one-pixel square still needs a 1-bit sub counter.
  localparam int SW = (SQ > 1) ? $clog2(SQ) : 1;

  logic [W-1:0]  pos_q, pos_d;
  logic [SW-1:0] sub_q, sub_d;
  logic          par_q, par_d;

  assign last = (pos_q == W'(N - 1));

  // Next position, sub-square count and parity.
  always_comb begin
    pos_d = pos_q;
    sub_d = sub_q;
    par_d = par_q;
    if (clr) begin
      pos_d = {W{1'b0}};
      sub_d = {SW{1'b0}};
      par_d = 1'b0;
    end else if (step) begin
      if (last) begin
        // Axis wrap also clears a partial final square.
        pos_d = {W{1'b0}};
        sub_d = {SW{1'b0}};
        par_d = 1'b0;
      end else begin
        pos_d = pos_q + {{(W-1){1'b0}}, 1'b1};
        if (sub_q == SW'(SQ - 1)) begin
          sub_d = {SW{1'b0}};
          par_d = ~par_q;
        end else begin
          sub_d = sub_q + {{(SW-1){1'b0}}, 1'b1};
          par_d = par_q;
        end
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // Axis state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pos_q <= {W{1'b0}};
      sub_q <= {SW{1'b0}};
      par_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      sub_q <= sub_d;
      par_q <= par_d;
    end
  end

  assign pos    = pos_q;
  assign parity = par_q;

endmodule

// File: rtl/chess_scan_ctrl.sv
// chess_scan_ctrl: raster-order sequencer for the chessboard pixel datapath.
// Emits one pixel per valid/ready transfer with coordinates, colour and
// frame markers; START/ABORT control, one-cycle DONE, latched colour invert.
//   CLK, RST        : clock, synchronous active-high reset
//   START / ABORT   : begin a frame (IDLE only) / cancel it (RUN only)
//   INVERT          : colour swap, captured when START is accepted
//   PIX_READY       : downstream accepts the presented pixel
//   PIX_VALID       : pixel outputs valid (whole of RUN)
//   PIX_DATA        : colour, 0 = dark, 1 = light
//   PIX_X / PIX_Y   : pixel coordinates
//   SOF / EOL / EOF : first pixel / last of line / last of frame
//   BUSY / DONE     : in RUN / one-cycle pulse after the final transfer
module chess_scan_ctrl
  import chess_pkg::*;
#(
  parameter int H_PIX = H_PIX_D,
  parameter int V_PIX = V_PIX_D,
  parameter int SQ    = SQ_D,
  parameter int XW    = $clog2(H_PIX),
  parameter int YW    = $clog2(V_PIX)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic          INVERT,
  input  logic          PIX_READY,
  output logic          PIX_VALID,
  output logic          PIX_DATA,
  output logic [XW-1:0] PIX_X,
  output logic [YW-1:0] PIX_Y,
  output logic          SOF,
  output logic          EOL,
  output logic          EOF,
  output logic          BUSY,
  output logic          DONE
);

  state_e state_q, state_d;
  logic   inv_q, inv_d;
  logic   valid_q, valid_d;
  logic   done_q, done_d;

  logic          cnt_clr_s;
  logic          xfer_s;
  logic          y_step_s;
  logic [XW-1:0] x_pos_s;
  logic [YW-1:0] y_pos_s;
  logic          x_last_s, y_last_s;
  logic          px_s, py_s;

  assign xfer_s   = valid_q & PIX_READY;
  assign y_step_s = xfer_s & x_last_s;

  chess_axis_cnt #(.N(H_PIX), .SQ(SQ), .W(XW)) u_x_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (cnt_clr_s),
    .step   (xfer_s),
    .pos    (x_pos_s),
    .parity (px_s),
    .last   (x_last_s)
  );

  chess_axis_cnt #(.N(V_PIX), .SQ(SQ), .W(YW)) u_y_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (cnt_clr_s),
    .step   (y_step_s),
    .pos    (y_pos_s),
    .parity (py_s),
    .last   (y_last_s)
  );

  // Sequencer next state, invert capture and counter clear.
  always_comb begin
    state_d   = state_q;
    inv_d     = inv_q;
    cnt_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = RUN;
          inv_d     = INVERT;
          cnt_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // ABORT wins over the final transfer; counters clear either way.
        if (ABORT) begin
          state_d   = IDLE;
          cnt_clr_s = 1'b1;
        end else if (PIX_READY && x_last_s && y_last_s) begin
          state_d = FIN;
        end else begin
          state_d = RUN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        cnt_clr_s = 1'b1;
      end
    endcase
    valid_d = (state_d == RUN);
    done_d  = (state_d == FIN);
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      inv_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Position and colour only move on a transfer, so a stall holds them.
  assign PIX_VALID = valid_q;
  assign BUSY      = valid_q;
  assign DONE      = done_q;
  assign PIX_X     = x_pos_s;
  assign PIX_Y     = y_pos_s;
  assign PIX_DATA  = valid_q & (px_s ^ py_s ^ inv_q);
  assign SOF       = valid_q & (x_pos_s == {XW{1'b0}}) & (y_pos_s == {YW{1'b0}});
  assign EOL       = valid_q & x_last_s;
  assign EOF       = valid_q & x_last_s & y_last_s;

endmodule

// File: tb/tb_chess_scan_ctrl.sv
// Bench for chess_scan_ctrl: a 4x4/SQ=2 instance for handshake and control
// cases and a 210x120/SQ=40 instance (partial final square) for a full frame.
// Expected pixels are queued from an arithmetic model when a frame starts
// and popped on every transfer.
module tb_chess_scan_ctrl;

  localparam int SH = 4,   SV = 4,   SS = 2;
  localparam int MH = 210, MV = 120, MS = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic s_start, s_abort, s_inv, s_ready;
  logic s_valid, s_data, s_sof, s_eol, s_eof, s_busy, s_done;
  logic [1:0] s_x, s_y;
  logic m_start, m_abort, m_inv, m_ready;
  logic m_valid, m_data, m_sof, m_eol, m_eof, m_busy, m_done;
  logic [7:0] m_x;
  logic [6:0] m_y;

  int checks = 0;
  int errors = 0;
  logic [31:0] s_q[$];
  logic [31:0] m_q[$];
  int s_xfers = 0, s_dones = 0;
  int m_xfers = 0, m_dones = 0, m_eols = 0, m_sofs = 0, m_eofs = 0;
  logic        s_stall_prev = 1'b0;
  logic [31:0] s_prev = 32'd0;
  int x0, d0;

  chess_scan_ctrl #(.H_PIX(SH), .V_PIX(SV), .SQ(SS)) u_small (
    .CLK(clk), .RST(rst), .START(s_start), .ABORT(s_abort), .INVERT(s_inv),
    .PIX_READY(s_ready), .PIX_VALID(s_valid), .PIX_DATA(s_data),
    .PIX_X(s_x), .PIX_Y(s_y), .SOF(s_sof), .EOL(s_eol), .EOF(s_eof),
    .BUSY(s_busy), .DONE(s_done)
  );

  chess_scan_ctrl #(.H_PIX(MH), .V_PIX(MV), .SQ(MS)) u_med (
    .CLK(clk), .RST(rst), .START(m_start), .ABORT(m_abort), .INVERT(m_inv),
    .PIX_READY(m_ready), .PIX_VALID(m_valid), .PIX_DATA(m_data),
    .PIX_X(m_x), .PIX_Y(m_y), .SOF(m_sof), .EOL(m_eol), .EOF(m_eof),
    .BUSY(m_busy), .DONE(m_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic d, input logic eol, input logic sof,
                                       input logic eof, input int x, input int y);
    return 32'(d) | (32'(eol) << 1) | (32'(sof) << 2) | (32'(eof) << 3)
         | (32'(x) << 4) | (32'(y) << 16);
  endfunction

  function automatic logic [31:0] exp_pix(input int x, input int y, input int h,
                                          input int v, input int sq, input int inv);
    logic d, eol, sof, eof;
    d   = (((x / sq) + (y / sq) + inv) % 2) == 1;
    sof = (x == 0) && (y == 0);
    eol = (x == h - 1);
    eof = eol && (y == v - 1);
    return pack(d, eol, sof, eof, x, y);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_small(input int inv);
    for (int y = 0; y < SV; y++)
      for (int x = 0; x < SH; x++)
        s_q.push_back(exp_pix(x, y, SH, SV, SS, inv));
  endtask

  task automatic push_med(input int inv);
    for (int y = 0; y < MV; y++)
      for (int x = 0; x < MH; x++)
        m_q.push_back(exp_pix(x, y, MH, MV, MS, inv));
  endtask

  // Small instance scoreboard, hold-while-stalled and DONE checks.
  always @(negedge clk) begin
    logic [31:0] cur;
    cur = pack(s_data, s_eol, s_sof, s_eof, int'(s_x), int'(s_y));
    if (!rst) begin
      if (s_stall_prev && s_valid) check("s_hold", cur, s_prev);
      if (s_valid && s_ready) begin
        s_xfers++;
        check("s_q_nonempty", 32'(s_q.size() != 0), 32'd1);
        if (s_q.size() != 0) check("s_pix", cur, s_q.pop_front());
      end
      if (s_done) begin
        s_dones++;
        check("s_done_busy_valid", 32'({s_busy, s_valid}), 32'd0);
      end
      s_stall_prev = s_valid && !s_ready;
      s_prev       = cur;
    end else begin
      s_stall_prev = 1'b0;
    end
  end

  // Medium instance scoreboard and marker counts.
  always @(negedge clk) begin
    logic [31:0] cur;
    cur = pack(m_data, m_eol, m_sof, m_eof, int'(m_x), int'(m_y));
    if (!rst) begin
      if (m_valid && m_ready) begin
        m_xfers++;
        if (m_eol) m_eols++;
        if (m_sof) m_sofs++;
        if (m_eof) m_eofs++;
        check("m_q_nonempty", 32'(m_q.size() != 0), 32'd1);
        if (m_q.size() != 0) check("m_pix", cur, m_q.pop_front());
      end
      if (m_done) begin
        m_dones++;
        check("m_done_busy_valid", 32'({m_busy, m_valid}), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    s_start = 1'b1; s_abort = 1'b0; s_inv = 1'b0; s_ready = 1'b0;
    m_start = 1'b1; m_abort = 1'b0; m_inv = 1'b0; m_ready = 1'b0;
    tick(3);
    check("rst_s_out", 32'({s_valid, s_data, s_x, s_y, s_sof, s_eol, s_eof, s_busy, s_done}), 32'd0);
    check("rst_m_out", 32'({m_valid, m_data, m_x, m_y, m_sof, m_eol, m_eof, m_busy, m_done}), 32'd0);
    rst = 1'b0; s_start = 1'b0; m_start = 1'b0;
    tick(3);
    check("idle_s", 32'({s_valid, s_busy, s_done}), 32'd0);
    check("idle_m", 32'({m_valid, m_busy, m_done}), 32'd0);

    // Backpressure frame, INVERT=0.
    push_small(0); x0 = s_xfers; d0 = s_dones;
    s_start = 1'b1; tick(1); s_start = 1'b0;
    check("bp_first", 32'({s_valid, s_sof, s_busy, s_x, s_y}), 32'b1110000);
    for (int i = 0; i < 300 && s_dones == d0; i++) begin
      s_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    check("bp_done", 32'(s_dones), 32'(d0 + 1));
    check("bp_xfers", 32'(s_xfers - x0), 32'd16);
    check("bp_q_empty", 32'(s_q.size()), 32'd0);

    // INVERT latched at START, dropped mid-frame; START held through RUN and FIN.
    s_ready = 1'b1;
    push_small(1); x0 = s_xfers; d0 = s_dones;
    s_inv = 1'b1; s_start = 1'b1; tick(1); s_start = 1'b0; s_inv = 1'b0;
    tick(3);
    s_start = 1'b1;
    for (int i = 0; i < 100 && s_dones == d0; i++) tick(1);
    s_start = 1'b0;
    tick(3);
    check("inv_done", 32'(s_dones), 32'(d0 + 1));
    check("inv_no_restart", 32'({s_valid, s_busy}), 32'd0);
    check("inv_xfers", 32'(s_xfers - x0), 32'd16);
    check("inv_q_empty", 32'(s_q.size()), 32'd0);

    // START with ABORT in IDLE, then ABORT on transfer 5.
    push_small(0); x0 = s_xfers; d0 = s_dones;
    s_abort = 1'b1; s_start = 1'b1; tick(1); s_start = 1'b0; s_abort = 1'b0;
    check("start_beats_abort", 32'(s_valid), 32'd1);
    for (int i = 0; i < 50 && (s_xfers - x0) < 4; i++) tick(1);
    s_abort = 1'b1; tick(1); s_abort = 1'b0;
    check("abort_idle", 32'({s_valid, s_busy, s_done}), 32'd0);
    check("abort_q_left", 32'(s_q.size()), 32'd11);
    s_q.delete();
    tick(3);
    check("abort_no_done", 32'(s_dones), 32'(d0));

    // Restart from (0,0), then RST on transfer 7.
    push_small(0); x0 = s_xfers; d0 = s_dones;
    s_start = 1'b1; tick(1); s_start = 1'b0;
    check("restart_sof", 32'({s_valid, s_sof, s_x, s_y}), 32'b110000);
    for (int i = 0; i < 50 && (s_xfers - x0) < 6; i++) tick(1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rst_mid_idle", 32'({s_valid, s_busy, s_done}), 32'd0);
    check("rst_mid_q_left", 32'(s_q.size()), 32'd10);
    s_q.delete();
    tick(3);
    check("rst_mid_no_done", 32'(s_dones), 32'(d0));

    // ABORT on the final transfer: no DONE, counters cleared.
    push_small(0); x0 = s_xfers; d0 = s_dones;
    s_start = 1'b1; tick(1); s_start = 1'b0;
    for (int i = 0; i < 50 && (s_xfers - x0) < 15; i++) tick(1);
    check("last_eof", 32'({s_eof, s_eol}), 32'b11);
    s_abort = 1'b1; tick(1); s_abort = 1'b0;
    check("abort_eof_idle", 32'({s_valid, s_busy, s_done, s_x, s_y}), 32'd0);
    tick(3);
    check("abort_eof_no_done", 32'(s_dones), 32'(d0));
    check("abort_eof_q_empty", 32'(s_q.size()), 32'd0);

    // Full frame on the medium instance.
    push_med(0);
    m_ready = 1'b1; m_start = 1'b1; tick(1); m_start = 1'b0;
    check("m_first", 32'({m_valid, m_sof, m_data}), 32'b110);
    for (int i = 0; i < 30000 && m_dones == 0; i++) tick(1);
    tick(3);
    check("m_done", 32'(m_dones), 32'd1);
    check("m_xfers", 32'(m_xfers), 32'(MH * MV));
    check("m_eols", 32'(m_eols), 32'(MV));
    check("m_sofs", 32'(m_sofs), 32'd1);
    check("m_eofs", 32'(m_eofs), 32'd1);
    check("m_q_empty", 32'(m_q.size()), 32'd0);
    check("m_idle", 32'({m_valid, m_busy, m_done}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
